param_sync_fifo: RTL

Parametrised single-clock FIFO that succeeds the fixed 8-bit/4-deep synchronous FIFO. It adds configurable width, depth and almost-flag thresholds, an occupancy count, and a first-word-fall-through (FWFT) mode. It also adds sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain and is the standard buffering element for new datapaths.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_ram.sv | 34 +++
 rtl/param_sync_fifo.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared helpers for param_sync_fifo: address-width function
//                and parameter legality predicates used at elaboration time.
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  // Number of address bits needed to index a memory of 'depth' entries.
  function automatic int unsigned fifo_addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // DEPTH must be a power of two no smaller than 2 so the wrap bit works.
  function automatic bit fifo_depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // almost_full threshold in 1..DEPTH, almost_empty threshold in 0..DEPTH-1.
  function automatic bit fifo_levels_ok(input int unsigned depth,
                                        input int unsigned af_level,
                                        input int unsigned ae_level);
    return (af_level >= 1) && (af_level <= depth) && (ae_level <= depth - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ram
//  Description : Simple dual-port DEPTH x WIDTH memory, synchronous write,
//                asynchronous (combinational) read. Contents are not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            we_i,
  input  logic [fifo_addr_w(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]                wdata_i,
  input  logic [fifo_addr_w(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]                rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Store the write word on the rising edge when enabled.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/param_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : param_sync_fifo
//  Description : Parametrised single-clock FIFO with occupancy count,
//                almost flags, sticky overflow/underflow and optional
//                first-word-fall-through read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned FWFT     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              data_in,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [WIDTH-1:0]              data_out,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [fifo_addr_w(DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int unsigned     c_aw    = fifo_addr_w(DEPTH);
  localparam int unsigned     c_pw    = c_aw + 1;
  localparam logic [c_pw-1:0] c_depth = c_pw'(DEPTH);
  localparam logic [c_pw-1:0] c_af    = c_pw'(AF_LEVEL);
  localparam logic [c_pw-1:0] c_ae    = c_pw'(AE_LEVEL);

  // Reject illegal configurations while elaborating.
  if (WIDTH < 1) begin : g_bad_width
    $error("param_sync_fifo: WIDTH=%0d must be at least 1", WIDTH);
  end
  if (!fifo_depth_ok(DEPTH)) begin : g_bad_depth
    $error("param_sync_fifo: DEPTH=%0d must be a power of two >= 2", DEPTH);
  end
  if (!fifo_levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("param_sync_fifo: AF_LEVEL=%0d / AE_LEVEL=%0d out of range for DEPTH=%0d",
           AF_LEVEL, AE_LEVEL, DEPTH);
  end

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [c_pw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_pw-1:0]  rd_ptr_q, rd_ptr_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic [WIDTH-1:0] w_ram_rdata;

  assign count        = wr_ptr_q - rd_ptr_q;
  assign full         = (count == c_depth);
  assign empty        = (count == '0);
  assign almost_full  = (count >= c_af);
  assign almost_empty = (count <= c_ae);

  // Both requests are judged against the flags before the edge.
  assign w_wr_acc = wr_en && !full;
  assign w_rd_acc = rd_en && !empty;

  // Next-state for pointers and sticky error flags; a new error beats clr_err.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + c_pw'(w_wr_acc);
    rd_ptr_d    = rd_ptr_q + c_pw'(w_rd_acc);
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end else if (clr_err) begin
      overflow_d = 1'b0;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end
  end

  // Pointer and error-flag state, cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_wr_acc),
    .waddr_i (wr_ptr_q[c_aw-1:0]),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q[c_aw-1:0]),
    .rdata_o (w_ram_rdata)
  );

  if (FWFT == 0) begin : g_std_read
    logic [WIDTH-1:0] dout_q;

    // Registered read port: capture the head entry on an accepted read.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout_q <= '0;
      end else if (w_rd_acc) begin
        dout_q <= w_ram_rdata;
      end
    end

    assign data_out = dout_q;
  end else begin : g_fwft_read
    // Head entry is always visible; meaningless while empty.
    assign data_out = w_ram_rdata;
  end

endmodule
`default_nettype wire
